// File: rtl/ir_nec_tx.sv
// ir_nec_tx: NEC infrared transmitter, serialises {~cmd,cmd,~addr,addr} LSB first on a carrier-modulated LED drive.
// Optional macro IR_NEC_REPEAT_EN: held send emits NEC repeat codes instead of re-sending the full frame.
`default_nettype none
`timescale 1ns/1ps

module ir_nec_tx #(
  parameter int CARRIER_HALF = 658,
  parameter int UNIT_TICKS   = 28125,
  parameter int GAP_UNITS    = 72
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_out
);

  localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_TICKS - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);
  localparam logic [6:0]    GAP_LEN   = 7'(GAP_UNITS);

  typedef enum logic [3:0] {
    IDLE, LEADER_MARK, LEADER_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
`ifdef IR_NEC_REPEAT_EN
    , REP_MARK, REP_SPACE, REP_STOP
`endif
  } state_t;

  state_t      state;
  logic [TW-1:0] tick;
  logic [6:0]  units;
  logic [CW-1:0] car_cnt;
  logic [31:0] shreg;
  logic [5:0]  bit_cnt;
  logic [6:0]  dur;
  logic        is_mark;
  logic        unit_last;

  // Length of the current state in NEC units; a 1 bit carries a 3u space.
  always_comb begin
    dur     = 7'd1;
    is_mark = 1'b0;
    case (state)
      LEADER_MARK:  begin dur = 7'd16; is_mark = 1'b1; end
      LEADER_SPACE: dur = 7'd8;
      BIT_MARK:     is_mark = 1'b1;
      BIT_SPACE:    dur = shreg[0] ? 7'd3 : 7'd1;
      STOP_MARK:    is_mark = 1'b1;
      GAP:          dur = GAP_LEN;
`ifdef IR_NEC_REPEAT_EN
      REP_MARK:     begin dur = 7'd16; is_mark = 1'b1; end
      REP_SPACE:    dur = 7'd4;
      REP_STOP:     is_mark = 1'b1;
`endif
      default:      dur = 7'd1;
    endcase
  end

  assign unit_last = (tick == TICK_LAST) && (units == dur - 7'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tick    <= '0;
      units   <= '0;
      car_cnt <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ir_out  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state != IDLE) begin
        if (unit_last) begin
          tick  <= '0;
          units <= '0;
        end else if (tick == TICK_LAST) begin
          tick  <= '0;
          units <= units + 7'd1;
        end else begin
          tick <= tick + 1'b1;
        end
      end

      // Carrier runs only inside marks; state transitions below override it.
      if (is_mark) begin
        if (car_cnt == CAR_LAST) begin
          car_cnt <= '0;
          ir_out  <= ~ir_out;
        end else begin
          car_cnt <= car_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (send) begin
            shreg   <= {~cmd, cmd, ~addr, addr};
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= LEADER_MARK;
            ir_out  <= 1'b1;
            car_cnt <= '0;
          end
        end
        LEADER_MARK: if (unit_last) begin
          state  <= LEADER_SPACE;
          ir_out <= 1'b0;
        end
        LEADER_SPACE: if (unit_last) begin
          state   <= BIT_MARK;
          ir_out  <= 1'b1;
          car_cnt <= '0;
        end
        BIT_MARK: if (unit_last) begin
          state  <= BIT_SPACE;
          ir_out <= 1'b0;
        end
        BIT_SPACE: if (unit_last) begin
          shreg   <= {1'b0, shreg[31:1]};
          bit_cnt <= bit_cnt + 6'd1;
          state   <= (bit_cnt == 6'd31) ? STOP_MARK : BIT_MARK;
          ir_out  <= 1'b1;
          car_cnt <= '0;
        end
        STOP_MARK: if (unit_last) begin
          state  <= GAP;
          ir_out <= 1'b0;
          done   <= 1'b1;
        end
        GAP: if (unit_last) begin
`ifdef IR_NEC_REPEAT_EN
          if (send) begin
            state   <= REP_MARK;
            ir_out  <= 1'b1;
            car_cnt <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
`ifdef IR_NEC_REPEAT_EN
        REP_MARK: if (unit_last) begin
          state  <= REP_SPACE;
          ir_out <= 1'b0;
        end
        REP_SPACE: if (unit_last) begin
          state   <= REP_STOP;
          ir_out  <= 1'b1;
          car_cnt <= '0;
        end
        REP_STOP: if (unit_last) begin
          state  <= GAP;
          ir_out <= 1'b0;
          done   <= 1'b1;
        end
`endif
        default: begin
          state  <= IDLE;
          ir_out <= 1'b0;
          busy   <= 1'b0;
          tick   <= '0;
          units  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ir_nec_tx.sv
// tb_ir_nec_tx: directed bench for ir_nec_tx; expected frame words are queued at send time and checked against decoded mark periods.
`default_nettype none
`timescale 1ns/1ps

module tb_ir_nec_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] cmd = 8'h00;
  logic       busy, done, ir_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ir_nec_tx #(.CARRIER_HALF(2), .UNIT_TICKS(8), .GAP_UNITS(4)) dut (
    .clk(clk), .reset(reset), .send(send), .addr(addr), .cmd(cmd),
    .busy(busy), .done(done), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge and queue the word the frame must carry.
  task automatic do_send(input logic [7:0] a, input logic [7:0] c, input logic hold);
    @(negedge clk);
    addr = a; cmd = c; send = 1'b1;
    exp_q.push_back({~c, c, ~a, a});
    @(negedge clk);
    if (!hold) send = 1'b0;
  endtask

  // Decode one frame from the first mark edge: mark starts are rises after >=3 idle cycles;
  // the start-to-start period gives 16 cycles for a 0 and 32 for a 1.
  task automatic decode_frame(input string tag, input int exp_lat, input int poke_at,
                              input logic [7:0] pa, input logic [7:0] pc,
                              input logic ps, input logic prel, output logic end_busy);
    int t, zeros, done_cnt, done_at, busy_lo, lead_err, stop_hi, per;
    int st[$];
    logic [31:0] word, exp_w;
    t = 0; zeros = 0; done_cnt = 0; done_at = -1; busy_lo = 0; lead_err = 0; stop_hi = 0;
    word = 'x;
    while (ir_out !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_latency"}, t, exp_lat);
    for (int c = 0; c < 1000; c++) begin
      if (ir_out === 1'b1 && (c == 0 || zeros >= 3)) st.push_back(c);
      zeros = (ir_out === 1'b1) ? 0 : zeros + 1;
      if (c < 192 && ir_out !== ((c < 128 && (c % 4) < 2) ? 1'b1 : 1'b0)) lead_err++;
      if (c >= 968 && ir_out !== 1'b0) stop_hi++;
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      if (busy !== 1'b1) busy_lo++;
      if (c == poke_at) begin addr = pa; cmd = pc; send = ps; end
      if (c == poke_at + 1 && prel) send = 1'b0;
      @(negedge clk);
    end
    end_busy = busy;
    for (int i = 0; i < 32; i++) begin
      if (st.size() > i + 2) begin
        per = st[i+2] - st[i+1];
        word[i] = (per == 32) ? 1'b1 : (per == 16) ? 1'b0 : 1'bx;
      end
    end
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_leader"}, lead_err, 0);
    chk({tag, "_marks"}, st.size(), 34);
    chk({tag, "_space_start"}, (st.size() > 1) ? st[1] : -1, 192);
    chk({tag, "_stop_start"}, (st.size() > 33) ? st[33] : -1, 960);
    chk({tag, "_word"}, word, exp_w);
    chk({tag, "_stop_len"}, stop_hi, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_at"}, done_at, 968);
    chk({tag, "_busy"}, busy_lo, 0);
  endtask

`ifdef IR_NEC_REPEAT_EN
  // Repeat code: 128-cycle mark, 32-cycle space, 8-cycle mark, then done and a 32-cycle gap.
  task automatic check_repeat(input string tag);
    int ir_err, done_cnt, done_at, busy_lo;
    logic e;
    ir_err = 0; done_cnt = 0; done_at = -1; busy_lo = 0;
    for (int r = 0; r < 200; r++) begin
      e = ((r < 128 || (r >= 160 && r < 168)) && (r % 4) < 2) ? 1'b1 : 1'b0;
      if (ir_out !== e) ir_err++;
      if (done === 1'b1) begin done_cnt++; done_at = r; end
      if (busy !== 1'b1) busy_lo++;
      if (r == 10) send = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_ir"}, ir_err, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_at"}, done_at, 168);
    chk({tag, "_busy"}, busy_lo, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask
`endif

  initial begin
    logic eb;
    int bad, dcnt;

    // Scenario 1: reset and idle.
    repeat (3) @(negedge clk);
    chk("rst_state", {done, busy, ir_out}, 3'b000);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({done, busy, ir_out} !== 3'b000) bad++;
    end
    chk("idle_50", bad, 0);

    // Scenario 2: all-zero frame.
    do_send(8'h00, 8'h00, 1'b0);
    chk("accept_busy", busy, 1);
    decode_frame("zero", 0, -1, 8'h00, 8'h00, 1'b0, 1'b0, eb);
    chk("zero_busy_end", eb, 0);

    // Scenario 3: mixed pattern.
    do_send(8'hA5, 8'h3C, 1'b0);
    decode_frame("a5_3c", 0, -1, 8'h00, 8'h00, 1'b0, 1'b0, eb);
    chk("a5_busy_end", eb, 0);

    // Scenario 4: reset mid-frame.
    do_send(8'h96, 8'h0F, 1'b0);
    repeat (299) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("abort_outputs", {done, busy, ir_out}, 3'b000);
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dcnt = 0; bad = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (ir_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_quiet", bad, 0);
    do_send(8'h96, 8'h0F, 1'b0);
    decode_frame("after_abort", 0, -1, 8'h00, 8'h00, 1'b0, 1'b0, eb);

    // Scenario 5: inputs and send poked mid-frame are ignored.
    do_send(8'h5A, 8'h81, 1'b0);
    decode_frame("poke", 0, 400, 8'hFF, 8'hFF, 1'b1, 1'b1, eb);
    chk("poke_busy_end", eb, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("poke_no_restart", bad, 0);

    // Scenario 6: send held across the frame end.
    do_send(8'h12, 8'hC4, 1'b1);
`ifdef IR_NEC_REPEAT_EN
    decode_frame("hold", 0, 500, 8'h77, 8'h66, 1'b1, 1'b0, eb);
    chk("hold_busy_end", eb, 1);
    check_repeat("repeat");
`else
    exp_q.push_back({~8'h66, 8'h66, ~8'h77, 8'h77});
    decode_frame("hold", 0, 500, 8'h77, 8'h66, 1'b1, 1'b0, eb);
    chk("hold_busy_end", eb, 0);
    decode_frame("resend", 1, 100, 8'h77, 8'h66, 1'b0, 1'b0, eb);
    chk("resend_busy_end", eb, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
